// File: rtl/crc16_frame_tx_if.sv
// Byte-stream handshake bundle for crc16_frame_tx: payload in, framed bytes out,
// plus the running CRC and busy status. The block sits on the slave modport.
interface crc16_frame_tx_if;
   logic [7:0]  i_data;
   logic        i_valid;
   logic        i_last;
   logic        o_ready;
   logic [7:0]  o_data;
   logic        o_valid;
   logic        o_last;
   logic        i_ready;
   logic [15:0] o_crc;
   logic        o_busy;

   modport slave (
      input  i_data, i_valid, i_last, i_ready,
      output o_ready, o_data, o_valid, o_last, o_crc, o_busy
   );

   modport master (
      output i_data, i_valid, i_last, i_ready,
      input  o_ready, o_data, o_valid, o_last, o_crc, o_busy
   );
endinterface

// File: rtl/crc16_frame_tx.sv
// Transmit framer: forwards payload bytes, runs a bit-serial CRC-16 (LSB first), and
// appends CRC low/high bytes at end of frame. Define CRC_FRAME_XOROUT_EN to invert the appended CRC.
module crc16_frame_tx #(
   parameter logic [15:0] CRC_INIT = 16'h0000,
   parameter logic [15:0] CRC_POLY = 16'h1021
) (
   input  logic             i_clk,
   input  logic             i_rst,
   crc16_frame_tx_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, SHIFT, SEND, CRC_LO, CRC_HI} state_t;

   state_t      state;
   state_t      state_nx;
   logic [2:0]  cnt;
   logic [7:0]  byte_q;
   logic        last_q;
   logic [15:0] crc;
   logic [15:0] crc_app;
   logic        in_frame;
   logic        in_xfer;
   logic        out_xfer;

   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      if (b == c[0])
         return c >> 1;
      else
         return (c >> 1) ^ CRC_POLY;
   endfunction

   function automatic logic [15:0] crc_out(input logic [15:0] c);
`ifdef CRC_FRAME_XOROUT_EN
      return c ^ 16'hFFFF;
`else
      return c;
`endif
   endfunction

   assign in_xfer  = bus.i_valid && bus.o_ready;
   assign out_xfer = bus.o_valid && bus.i_ready;
   assign crc_app  = crc_out(crc);

   always_ff @(posedge i_clk) begin
      if (i_rst)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_xfer) state_nx = SHIFT;
         SHIFT:   if (cnt == 3'd7) state_nx = SEND;
         SEND:    if (out_xfer) state_nx = last_q ? CRC_LO : IDLE;
         CRC_LO:  if (out_xfer) state_nx = CRC_HI;
         CRC_HI:  if (out_xfer) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.o_ready = 1'b0;
      bus.o_valid = 1'b0;
      bus.o_last  = 1'b0;
      bus.o_data  = 8'h00;
      case (state)
         IDLE:   bus.o_ready = 1'b1;
         SEND: begin
            bus.o_valid = 1'b1;
            bus.o_data  = byte_q;
         end
         CRC_LO: begin
            bus.o_valid = 1'b1;
            bus.o_data  = crc_app[7:0];
         end
         CRC_HI: begin
            bus.o_valid = 1'b1;
            bus.o_data  = crc_app[15:8];
            bus.o_last  = 1'b1;
         end
         default: ;
      endcase
   end

   // in_frame covers the IDLE gaps between payload bytes of one frame
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt      <= 3'd0;
         byte_q   <= 8'h00;
         last_q   <= 1'b0;
         crc      <= CRC_INIT;
         in_frame <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_xfer) begin
                  byte_q   <= bus.i_data;
                  last_q   <= bus.i_last;
                  cnt      <= 3'd0;
                  in_frame <= 1'b1;
               end
            end
            SHIFT: begin
               crc <= crc_step(crc, byte_q[cnt]);
               cnt <= cnt + 3'd1;
            end
            CRC_HI: begin
               if (out_xfer) begin
                  crc      <= CRC_INIT;
                  in_frame <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.o_crc  = crc;
   assign bus.o_busy = (state != IDLE) || in_frame;

endmodule

// File: tb/tb_crc16_frame_tx.sv
// Randomized and directed bench for crc16_frame_tx against a byte-level CRC model.
module tb_crc16_frame_tx;

   localparam logic [15:0] INIT = 16'h0000;
   localparam logic [15:0] POLY = 16'h1021;

   typedef struct {
      logic [7:0]  d;
      logic        l;
      logic [15:0] c;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   crc16_frame_tx_if bus();

   crc16_frame_tx #(.CRC_INIT(INIT), .CRC_POLY(POLY)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic [15:0] m_crc = INIT;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: 5-cycle stall per byte

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: CRC over a whole byte, bit by bit LSB first
   function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c;
      for (int i = 0; i < 8; i++) begin
         if (d[i] == r[0]) r = r >> 1;
         else              r = (r >> 1) ^ POLY;
      end
      return r;
   endfunction

   function automatic logic [15:0] appended(input logic [15:0] c);
`ifdef CRC_FRAME_XOROUT_EN
      return c ^ 16'hFFFF;
`else
      return c;
`endif
   endfunction

   task automatic model_push(input logic [7:0] d, input logic l);
      logic [15:0] a;
      m_crc = crc_byte(m_crc, d);
      exp_q.push_back('{d: d, l: 1'b0, c: m_crc});
      if (l) begin
         a = appended(m_crc);
         exp_q.push_back('{d: a[7:0],  l: 1'b0, c: m_crc});
         exp_q.push_back('{d: a[15:8], l: 1'b1, c: m_crc});
         m_crc = INIT;
      end
   endtask

   // i_ready driver
   int   w = -1;
   logic pv = 1'b0, pr = 1'b0;
   always begin
      @(posedge clk);
      #1;
      if (!bus.o_valid)   w = -1;
      else if (pv && pr)  w = 0;
      else                w++;
      case (rdy_mode)
         1:       bus.i_ready = ($urandom_range(0, 3) != 0);
         2:       bus.i_ready = (w >= 5);
         default: bus.i_ready = 1'b1;
      endcase
      pv = bus.o_valid;
      pr = bus.i_ready;
   end

   // Output scoreboard, sampled on the falling edge
   logic        stall_prev = 1'b0;
   logic [7:0]  sd;
   logic        sl;
   logic [15:0] sc;
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (stall_prev) begin
            chk("hold_valid", 32'(bus.o_valid), 32'd1);
            chk("hold_data",  32'({bus.o_last, bus.o_data, bus.o_crc}), 32'({sl, sd, sc}));
         end
         if (bus.o_valid) chk("ready_low_while_valid", 32'(bus.o_ready), 32'd0);
         if (bus.o_valid && bus.i_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_byte", 32'(bus.o_data), 32'h1ff);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(bus.o_data), 32'(e.d));
               chk("out_last", 32'(bus.o_last), 32'(e.l));
               chk("out_crc",  32'(bus.o_crc),  32'(e.c));
            end
         end
         stall_prev = bus.o_valid && !bus.i_ready;
         sd = bus.o_data;
         sl = bus.o_last;
         sc = bus.o_crc;
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l, input logic hold,
                            output int busy_low);
      logic rdy;
      int   n;
      bus.i_data  = d;
      bus.i_last  = l;
      bus.i_valid = 1'b1;
      busy_low = 0;
      n = 0;
      forever begin
         rdy = bus.o_ready;
         if (!bus.o_busy) busy_low++;
         tick();
         n++;
         if (rdy) break;
         if (n > 300) begin
            chk("accept_timeout", 32'(n), 32'd0);
            break;
         end
      end
      model_push(d, l);
      if (!hold) begin
         bus.i_valid = 1'b0;
         bus.i_data  = 8'($urandom);
         bus.i_last  = 1'($urandom);
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && bus.o_ready)) begin
         tick();
         n++;
         if (n > 500) begin
            chk("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      exp_q.delete();
      m_crc = INIT;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int bl;
      int k;
      int len;
      bus.i_data  = 8'h00;
      bus.i_valid = 1'b0;
      bus.i_last  = 1'b0;
      bus.i_ready = 1'b1;

      // Model pinned to hand-computed values
      chk("model_f8",   32'(crc_byte(16'h0000, 8'hF8)), 32'h152B);
      chk("model_f881", 32'(crc_byte(16'h152B, 8'h81)), 32'h1CED);
`ifdef CRC_FRAME_XOROUT_EN
      chk("model_xorout", 32'(appended(16'h152B)), 32'hEAD4);
`else
      chk("model_xorout", 32'(appended(16'h152B)), 32'h152B);
`endif

      tick();
      tick();
      rst = 1'b0;
      chk("rst_ready", 32'(bus.o_ready), 32'd1);
      chk("rst_valid", 32'(bus.o_valid), 32'd0);
      chk("rst_last",  32'(bus.o_last),  32'd0);
      chk("rst_data",  32'(bus.o_data),  32'h00);
      chk("rst_crc",   32'(bus.o_crc),   32'(INIT));
      chk("rst_busy",  32'(bus.o_busy),  32'd0);

      // Single-byte frame: latency and CRC
      send_byte(8'hF8, 1'b1, 1'b0, bl);
      chk("t1_ready_after_accept", 32'(bus.o_ready), 32'd0);
      k = 0;
      while (!bus.o_valid && k < 50) begin
         tick();
         k++;
      end
      chk("t1_latency", 32'(k), 32'd8);
      chk("t1_crc",     32'(bus.o_crc), 32'h152B);
      wait_idle();

      // Two-byte frame
      send_byte(8'hF8, 1'b0, 1'b0, bl);
      send_byte(8'h81, 1'b1, 1'b0, bl);
      chk("t2_busy_between_bytes", 32'(bl), 32'd0);
      repeat (8) tick();
      chk("t2_send_data", 32'(bus.o_data), 32'h81);
      chk("t2_crc",       32'(bus.o_crc),  32'h1CED);
      wait_idle();
      chk("t2_crc_reinit", 32'(bus.o_crc), 32'h0000);

      // Backpressure on every output byte
      rdy_mode = 2;
      send_byte(8'hF8, 1'b0, 1'b0, bl);
      send_byte(8'h81, 1'b1, 1'b0, bl);
      wait_idle();
      rdy_mode = 0;
      tick();

      // Reset during SHIFT with cnt=3
      send_byte(8'hF8, 1'b1, 1'b0, bl);
      repeat (3) tick();
      do_reset();
      chk("t5a_valid", 32'(bus.o_valid), 32'd0);
      chk("t5a_ready", 32'(bus.o_ready), 32'd1);
      chk("t5a_crc",   32'(bus.o_crc),   32'h0000);
      chk("t5a_busy",  32'(bus.o_busy),  32'd0);

      // Reset in CRC_LO, coinciding with an output transfer
      send_byte(8'hF8, 1'b1, 1'b0, bl);
      repeat (9) tick();
      chk("t5b_in_crc_lo", 32'({bus.o_valid, bus.o_data}), 32'h12B);
      do_reset();
      chk("t5b_valid", 32'(bus.o_valid), 32'd0);
      chk("t5b_ready", 32'(bus.o_ready), 32'd1);
      chk("t5b_crc",   32'(bus.o_crc),   32'h0000);
      send_byte(8'hF8, 1'b1, 1'b0, bl);
      wait_idle();

      // Back-to-back frames with i_valid held high
      send_byte(8'hF8, 1'b1, 1'b1, bl);
      send_byte(8'hF8, 1'b1, 1'b0, bl);
      chk("t6_busy_gap", 32'(bl), 32'd1);
      wait_idle();

      // Randomized frames with random backpressure and input gaps
      rdy_mode = 1;
      for (int f = 0; f < 60; f++) begin
         len = $urandom_range(1, 5);
         for (int b = 0; b < len; b++) begin
            repeat ($urandom_range(0, 2)) tick();
            send_byte(8'($urandom), (b == len - 1), 1'b0, bl);
         end
      end
      wait_idle();
      rdy_mode = 0;
      repeat (3) tick();
      chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("final_busy",        32'(bus.o_busy),   32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
